// File: rtl/key_debounce_if.sv
// key_debounce_if
//   Groups the raw key pins and the debounced key outputs of key_debounce.
//   master : board/stimulus side, drives KEY_N, observes the results.
//   slave  : debouncer side, samples KEY_N, drives the results.
// Signals (all N_KEYS wide, one bit per key channel):
//   KEY_N       raw active-low key pins, asynchronous to the clock
//   KEY_LEVEL   debounced level, 1 = pressed
//   KEY_PRESS   one-cycle pulse on an accepted press
//   KEY_RELEASE one-cycle pulse on an accepted release
//   KEY_LONG    one-cycle pulse when a press has been held LONG_CYC cycles
interface key_debounce_if #(
    parameter int N_KEYS = 2
);
    logic [N_KEYS-1:0] KEY_N;
    logic [N_KEYS-1:0] KEY_LEVEL;
    logic [N_KEYS-1:0] KEY_PRESS;
    logic [N_KEYS-1:0] KEY_RELEASE;
    logic [N_KEYS-1:0] KEY_LONG;

    modport master (
        output KEY_N,
        input  KEY_LEVEL, KEY_PRESS, KEY_RELEASE, KEY_LONG
    );

    modport slave (
        input  KEY_N,
        output KEY_LEVEL, KEY_PRESS, KEY_RELEASE, KEY_LONG
    );
endinterface

// File: rtl/key_debounce.sv
// key_debounce
//   Debounced reader for active-low push buttons. Each channel has a
//   two-flop synchroniser, a stable-time counter FSM and a hold counter,
//   and reports a clean level plus one-cycle press/release/long pulses.
// Ports:
//   CLK_IN  single clock, rising edge
//   RST_N   asynchronous active-low reset
//   bus     key_debounce_if.slave (KEY_N in; KEY_LEVEL/PRESS/RELEASE/LONG out)

// One key channel.
//   i_clk, i_rst_n  clock / async active-low reset
//   i_key_n         raw active-low pin
//   o_level         debounced level (1 = pressed)
//   o_press, o_release, o_long  one-cycle event pulses
module key_debounce_lane #(
    parameter int DEBOUNCE_CYC = 240_000,
    parameter int LONG_CYC     = 24_000_000,
    parameter int CNT_W        = 25
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_key_n,
    output logic o_level,
    output logic o_press,
    output logic o_release,
    output logic o_long
);
    localparam logic [CNT_W-1:0] DB_MAX   = CNT_W'(DEBOUNCE_CYC - 1);
    localparam logic [CNT_W-1:0] LONG_MAX = CNT_W'(LONG_CYC - 1);

    typedef enum logic [1:0] {IDLE, DB_PRESS, HELD, DB_RELEASE} state_t;

    state_t           r_state;
    logic [1:0]       r_sync;
    logic [CNT_W-1:0] r_db_cnt;
    logic [CNT_W-1:0] r_hold_cnt;
    logic             r_long_done;
    logic             w_s;

    // Synchronised "pressed" level; the FSM looks at nothing else.
    assign w_s = r_sync[1];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state     <= IDLE;
            r_sync      <= '0;
            r_db_cnt    <= '0;
            r_hold_cnt  <= '0;
            r_long_done <= 1'b0;
            o_level     <= 1'b0;
            o_press     <= 1'b0;
            o_release   <= 1'b0;
            o_long      <= 1'b0;
        end else begin
            r_sync    <= {r_sync[0], ~i_key_n};
            o_press   <= 1'b0;
            o_release <= 1'b0;
            o_long    <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_s) begin
                        r_state  <= DB_PRESS;
                        r_db_cnt <= '0;
                    end
                end
                DB_PRESS: begin
                    if (!w_s) begin
                        r_state <= IDLE;
                    end else if (r_db_cnt == DB_MAX) begin
                        r_state     <= HELD;
                        o_level     <= 1'b1;
                        o_press     <= 1'b1;
                        r_hold_cnt  <= '0;
                        r_long_done <= 1'b0;
                    end else begin
                        r_db_cnt <= r_db_cnt + 1'b1;
                    end
                end
                HELD: begin
                    // Hold time only advances while in HELD, so cycles
                    // spent in a release glitch push KEY_LONG out.
                    if (r_hold_cnt != LONG_MAX)
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                    if (r_hold_cnt == LONG_MAX && !r_long_done) begin
                        o_long      <= 1'b1;
                        r_long_done <= 1'b1;
                    end
                    if (!w_s) begin
                        r_state  <= DB_RELEASE;
                        r_db_cnt <= '0;
                    end
                end
                DB_RELEASE: begin
                    if (w_s) begin
                        r_state <= HELD;
                    end else if (r_db_cnt == DB_MAX) begin
                        r_state    <= IDLE;
                        o_level    <= 1'b0;
                        o_release  <= 1'b1;
                        r_hold_cnt <= '0;
                    end else begin
                        r_db_cnt <= r_db_cnt + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

module key_debounce #(
    parameter int N_KEYS       = 2,
    parameter int DEBOUNCE_CYC = 240_000,
    parameter int LONG_CYC     = 24_000_000,
    parameter int CNT_W        = 25
) (
    input  logic           CLK_IN,
    input  logic           RST_N,
    key_debounce_if.slave  bus
);
    logic [N_KEYS-1:0] w_level;
    logic [N_KEYS-1:0] w_press;
    logic [N_KEYS-1:0] w_release;
    logic [N_KEYS-1:0] w_long;

    for (genvar g = 0; g < N_KEYS; g++) begin : g_lane
        key_debounce_lane #(
            .DEBOUNCE_CYC (DEBOUNCE_CYC),
            .LONG_CYC     (LONG_CYC),
            .CNT_W        (CNT_W)
        ) u_lane (
            .i_clk     (CLK_IN),
            .i_rst_n   (RST_N),
            .i_key_n   (bus.KEY_N[g]),
            .o_level   (w_level[g]),
            .o_press   (w_press[g]),
            .o_release (w_release[g]),
            .o_long    (w_long[g])
        );
    end

    assign bus.KEY_LEVEL   = w_level;
    assign bus.KEY_PRESS   = w_press;
    assign bus.KEY_RELEASE = w_release;
    assign bus.KEY_LONG    = w_long;
endmodule

// File: tb/tb_key_debounce.sv
// tb_key_debounce
//   Directed bench for key_debounce with N_KEYS=2, DEBOUNCE_CYC=4,
//   LONG_CYC=20. Inputs change 1 ns after a rising edge, so the next
//   rising edge is "edge 0"; outputs are observed 1 ns after each edge.
module tb_key_debounce;
    logic CLK_IN;
    logic RST_N;
    int   checks;
    int   errors;

    key_debounce_if #(.N_KEYS(2)) bus ();

    key_debounce #(
        .N_KEYS       (2),
        .DEBOUNCE_CYC (4),
        .LONG_CYC     (20),
        .CNT_W        (5)
    ) dut (
        .CLK_IN (CLK_IN),
        .RST_N  (RST_N),
        .bus    (bus)
    );

    initial CLK_IN = 1'b0;
    always #5 CLK_IN = ~CLK_IN;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK_IN);
        #1;
    endtask

    // Observe n edges (0..n-1). Pulse output 'sel' (0 press, 1 release,
    // 2 long) must equal ev_val on edge ev_edge and 0 elsewhere; the other
    // two pulse outputs must stay 0. Level is lv_a before ev_edge, lv_b from it.
    task automatic watch(input string tag, input int n, input int ev_edge,
                         input logic [1:0] ev_val, input int sel,
                         input logic [1:0] lv_a, input logic [1:0] lv_b);
        for (int e = 0; e < n; e++) begin
            logic [1:0] ev;
            step();
            ev = (e == ev_edge) ? ev_val : 2'b00;
            chk($sformatf("%s.press@%0d", tag, e),   32'(bus.KEY_PRESS),   32'(sel == 0 ? ev : 2'b00));
            chk($sformatf("%s.release@%0d", tag, e), 32'(bus.KEY_RELEASE), 32'(sel == 1 ? ev : 2'b00));
            chk($sformatf("%s.long@%0d", tag, e),    32'(bus.KEY_LONG),    32'(sel == 2 ? ev : 2'b00));
            chk($sformatf("%s.level@%0d", tag, e),   32'(bus.KEY_LEVEL),   32'(e < ev_edge ? lv_a : lv_b));
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".level"},   32'(bus.KEY_LEVEL),   32'd0);
        chk({tag, ".press"},   32'(bus.KEY_PRESS),   32'd0);
        chk({tag, ".release"}, 32'(bus.KEY_RELEASE), 32'd0);
        chk({tag, ".long"},    32'(bus.KEY_LONG),    32'd0);
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        RST_N     = 1'b0;
        bus.KEY_N = 2'b11;
        #12;
        chk_all_zero("reset");
        step();
        RST_N = 1'b1;
        watch("idle", 4, -1, 2'b00, 0, 2'b00, 2'b00);

        // Clean press on key 0: press/level rise on edge 6; key 1 silent.
        bus.KEY_N = 2'b10;
        watch("press", 7, 6, 2'b01, 0, 2'b00, 2'b01);
        // Long press: KEY_LONG 20 edges after the press edge, exactly once.
        watch("long", 40, 19, 2'b01, 2, 2'b01, 2'b01);
        // Clean release.
        bus.KEY_N = 2'b11;
        watch("rel", 8, 6, 2'b01, 1, 2'b01, 2'b00);

        // Bounce: 3 cycles low, then high -> nothing.
        bus.KEY_N = 2'b10;
        watch("bnc_lo", 3, -1, 2'b00, 0, 2'b00, 2'b00);
        bus.KEY_N = 2'b11;
        watch("bnc_hi", 10, -1, 2'b00, 0, 2'b00, 2'b00);

        // Fresh press still needs the full 6 edges, so the FSM was IDLE.
        bus.KEY_N = 2'b10;
        watch("press2", 7, 6, 2'b01, 0, 2'b00, 2'b01);
        watch("g_hold", 5, -1, 2'b00, 1, 2'b01, 2'b01);
        // Glitch high for 2 cycles: 2 edges spent in DB_RELEASE, so the
        // long pulse moves from P+20 to P+22 (index 14 of this window).
        bus.KEY_N = 2'b11;
        watch("g_hi", 2, -1, 2'b00, 1, 2'b01, 2'b01);
        bus.KEY_N = 2'b10;
        watch("g_long", 25, 14, 2'b01, 2, 2'b01, 2'b01);
        bus.KEY_N = 2'b11;
        watch("rel2", 8, 6, 2'b01, 1, 2'b01, 2'b00);

        // Both keys together.
        bus.KEY_N = 2'b00;
        watch("both_p", 8, 6, 2'b11, 0, 2'b00, 2'b11);
        bus.KEY_N = 2'b11;
        watch("both_r", 8, 6, 2'b11, 1, 2'b11, 2'b00);

        // Async reset mid-HELD, between edges.
        bus.KEY_N = 2'b10;
        watch("rp", 10, 6, 2'b01, 0, 2'b00, 2'b01);
        #2;
        RST_N = 1'b0;
        #1;
        chk_all_zero("async_rst");
        step();
        step();
        chk_all_zero("in_rst");
        RST_N = 1'b1;
        watch("rst_press", 8, 6, 2'b01, 0, 2'b00, 2'b01);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
